smartbing_sensor_cond: RTL and testbench



---
 rtl/smartbing_sensor_cond.sv | 149 ++++++++++++++
 tb/tb_smartbing_sensor_cond.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/smartbing_sensor_cond.sv
// smartbing_sensor_cond: synchronises and debounces the su/lh/ll bin sensors,
// produces clean levels with one-cycle rise pulses, and raises a sticky fault
// when the high-level sensor reads active while the low-level sensor does not.
// Optional feature macro: SMARTBING_FALL_PULSE_EN adds o_su_fall/o_lh_fall/o_ll_fall.
// Channel index order everywhere: [0]=su, [1]=lh, [2]=ll.
module smartbing_sensor_cond #(
    parameter int unsigned DEB_CYCLES   = 8,
    parameter int unsigned PLAUS_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_su_raw,
    input  logic i_lh_raw,
    input  logic i_ll_raw,
    input  logic i_fault_clr,
    output logic o_su_lvl,
    output logic o_lh_lvl,
    output logic o_ll_lvl,
    output logic o_su_rise,
    output logic o_lh_rise,
    output logic o_ll_rise,
`ifdef SMARTBING_FALL_PULSE_EN
    output logic o_su_fall,
    output logic o_lh_fall,
    output logic o_ll_fall,
`endif
    output logic o_fault
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam int unsigned PW = $clog2(PLAUS_CYCLES + 1);
    localparam logic [PW-1:0] PLAUS_LIM = PW'(PLAUS_CYCLES);

    logic [2:0]    w_raw;
    logic [2:0]    r_s1;
    logic [2:0]    r_s2;
    logic [2:0]    r_stable;
    logic [2:0]    r_rise;
    logic [2:0]    w_flip;
    logic [CW-1:0] r_cnt [3];
    logic [PW-1:0] r_pcnt;
    logic [PW-1:0] w_pcnt_next;
    logic          w_cond;
    logic          r_fault;

    assign w_raw = {i_ll_raw, i_lh_raw, i_su_raw};

    // Per channel: stable value takes the synchronised value on this edge
    always_comb begin
        w_flip = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            w_flip[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == DEB_LAST);
        end
    end

    // Two-flop synchronisers keep sampling regardless of enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Debounce counters and stable levels, frozen while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (i_en) begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_flip[i]) begin
                    r_stable[i] <= r_s2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Rise pulses register alongside the level update so both appear together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= '0;
        end else begin
            r_rise <= i_en ? (w_flip & r_s2) : '0;
        end
    end

`ifdef SMARTBING_FALL_PULSE_EN
    logic [2:0] r_fall;

    // Fall pulses, same timing and gating as the rise pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fall <= '0;
        end else begin
            r_fall <= i_en ? (w_flip & ~r_s2) : '0;
        end
    end

    assign o_su_fall = r_fall[0];
    assign o_lh_fall = r_fall[1];
    assign o_ll_fall = r_fall[2];
`endif

    // Implausible when high-level reads active but low-level does not
    assign w_cond      = r_stable[1] & ~r_stable[2];
    assign w_pcnt_next = (r_pcnt == PLAUS_LIM) ? r_pcnt : r_pcnt + 1'b1;

    // Saturating plausibility counter and sticky fault; clear only honoured
    // while the condition is false
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt  <= '0;
            r_fault <= 1'b0;
        end else if (i_en) begin
            if (w_cond) begin
                r_pcnt <= w_pcnt_next;
                if (w_pcnt_next == PLAUS_LIM) begin
                    r_fault <= 1'b1;
                end
            end else begin
                r_pcnt <= '0;
                if (i_fault_clr) begin
                    r_fault <= 1'b0;
                end
            end
        end
    end

    assign o_su_lvl  = r_stable[0];
    assign o_lh_lvl  = r_stable[1];
    assign o_ll_lvl  = r_stable[2];
    assign o_su_rise = r_rise[0];
    assign o_lh_rise = r_rise[1];
    assign o_ll_rise = r_rise[2];
    assign o_fault   = r_fault;

endmodule

// File: tb/tb_smartbing_sensor_cond.sv
// Testbench for smartbing_sensor_cond: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model of the sensor rules.
module tb_smartbing_sensor_cond;

    localparam int DEB = 8;
    localparam int PL  = 16;

    logic clk = 1'b0;
    logic rst_n, en, su_raw, lh_raw, ll_raw, fault_clr;
    logic su_lvl, lh_lvl, ll_lvl, su_rise, lh_rise, ll_rise, fault;
`ifdef SMARTBING_FALL_PULSE_EN
    logic su_fall, lh_fall, ll_fall;
`endif

    smartbing_sensor_cond #(.DEB_CYCLES(DEB), .PLAUS_CYCLES(PL)) dut (
        .clk(clk), .rst_n(rst_n), .i_en(en),
        .i_su_raw(su_raw), .i_lh_raw(lh_raw), .i_ll_raw(ll_raw),
        .i_fault_clr(fault_clr),
        .o_su_lvl(su_lvl), .o_lh_lvl(lh_lvl), .o_ll_lvl(ll_lvl),
        .o_su_rise(su_rise), .o_lh_rise(lh_rise), .o_ll_rise(ll_rise),
`ifdef SMARTBING_FALL_PULSE_EN
        .o_su_fall(su_fall), .o_lh_fall(lh_fall), .o_ll_fall(ll_fall),
`endif
        .o_fault(fault)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raw values travel through a two-stage delay; a level
    // adopts the delayed value once it has disagreed for DEB enabled edges in a row.
    logic [2:0] m_p1, m_p2, m_lvl, m_rise, m_fall;
    int         m_streak [3];
    int         m_pc;
    logic       m_fault;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_p1 = '0; m_p2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
        for (int c = 0; c < 3; c++) m_streak[c] = 0;
        m_pc = 0;
        m_fault = 1'b0;
    endfunction

    // Called right after a rising edge, before inputs change
    function automatic void model_edge();
        logic [2:0] raw;
        logic cond;
        raw  = {ll_raw, lh_raw, su_raw};
        cond = m_lvl[1] & ~m_lvl[2];
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_rise = '0;
        m_fall = '0;
        if (en) begin
            if (cond) begin
                if (m_pc < PL) m_pc++;
                if (m_pc == PL) m_fault = 1'b1;
            end else begin
                m_pc = 0;
                if (fault_clr) m_fault = 1'b0;
            end
            for (int c = 0; c < 3; c++) begin
                if (m_p2[c] != m_lvl[c]) begin
                    m_streak[c]++;
                    if (m_streak[c] == DEB) begin
                        m_lvl[c] = m_p2[c];
                        m_streak[c] = 0;
                        if (m_lvl[c]) m_rise[c] = 1'b1;
                        else          m_fall[c] = 1'b1;
                    end
                end else begin
                    m_streak[c] = 0;
                end
            end
        end
        m_p2 = m_p1;
        m_p1 = raw;
    endfunction

    function automatic logic [9:0] dut_vec();
        logic [2:0] f;
`ifdef SMARTBING_FALL_PULSE_EN
        f = {ll_fall, lh_fall, su_fall};
`else
        f = 3'b000;
`endif
        return {fault, f, ll_rise, lh_rise, su_rise, ll_lvl, lh_lvl, su_lvl};
    endfunction

    function automatic logic [9:0] exp_vec();
        logic [2:0] f;
`ifdef SMARTBING_FALL_PULSE_EN
        f = m_fall;
`else
        f = 3'b000;
`endif
        return {m_fault, f, m_rise, m_lvl};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("cycle_model", 32'(dut_vec()), 32'(exp_vec()));
    endtask

    int n, cnt;

    initial begin
        rst_n = 1'b0; en = 1'b1; fault_clr = 1'b0;
        su_raw = 1'b1; lh_raw = 1'b1; ll_raw = 1'b1;
        model_reset();

        // 1: reset with all raw high, then levels rise together
        repeat (3) step();
        check("reset_outputs", 32'(dut_vec()), 32'd0);
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (su_lvl & lh_lvl & ll_lvl) begin n = i; break; end
        end
        check("t1_latency", 32'(n), 32'd10);
        check("t1_rise", 32'({ll_rise, lh_rise, su_rise}), 32'b111);
        step();
        check("t1_rise_once", 32'({ll_rise, lh_rise, su_rise}), 32'b000);

        // 2: short su glitch is rejected
        su_raw = 1'b0;
        repeat (12) step();
        check("t2_pre_lvl", 32'(su_lvl), 32'd0);
        su_raw = 1'b1;
        repeat (5) step();
        su_raw = 1'b0;
        cnt = 0;
        repeat (20) begin step(); cnt += int'(su_rise); end
        check("t2_no_rise", 32'(cnt), 32'd0);
        check("t2_lvl", 32'(su_lvl), 32'd0);

        // 3: chatter then settle high
        repeat (20) begin su_raw = ~su_raw; step(); end
        su_raw = 1'b1;
        n = 0; cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            cnt += int'(su_rise);
            if (su_lvl && n == 0) n = i;
        end
        check("t3_latency", 32'(n), 32'd10);
        check("t3_single_rise", 32'(cnt), 32'd1);

        // 4: plausibility fault and clear rules
        ll_raw = 1'b0;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (!ll_lvl) begin n = i; break; end
        end
        check("t4_ll_fall_latency", 32'(n), 32'd10);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (fault) begin n = i; break; end
        end
        check("t4_fault_delay", 32'(n), 32'(PL));
        fault_clr = 1'b1; step(); fault_clr = 1'b0;
        check("t4_clr_ignored", 32'(fault), 32'd1);
        ll_raw = 1'b1;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (ll_lvl) begin n = i; break; end
        end
        check("t4_ll_rise_latency", 32'(n), 32'd10);
        check("t4_fault_sticky", 32'(fault), 32'd1);
        fault_clr = 1'b1; step(); fault_clr = 1'b0;
        check("t4_clr", 32'(fault), 32'd0);

        // 5: freeze mid-debounce and resume
        ll_raw = 1'b0;
        repeat (12) step();
        check("t5_pre_lvl", 32'(ll_lvl), 32'd0);
        ll_raw = 1'b1;
        repeat (6) step();
        en = 1'b0;
        cnt = 0;
        repeat (10) begin
            step();
            cnt += int'(su_rise) + int'(lh_rise) + int'(ll_rise);
`ifdef SMARTBING_FALL_PULSE_EN
            cnt += int'(su_fall) + int'(lh_fall) + int'(ll_fall);
`endif
        end
        check("t5_no_pulse_frozen", 32'(cnt), 32'd0);
        check("t5_frozen_lvl", 32'(ll_lvl), 32'd0);
        en = 1'b1;
        repeat (3) step();
        check("t5_lvl_before", 32'(ll_lvl), 32'd0);
        step();
        check("t5_lvl_after", 32'(ll_lvl), 32'd1);
        check("t5_rise", 32'(ll_rise), 32'd1);
        step();
        check("t5_rise_once", 32'(ll_rise), 32'd0);

        // 6: su falls (pulse when enabled by the feature), then reset mid-debounce
        su_raw = 1'b0;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (!su_lvl) begin n = i; break; end
        end
        check("t6_fall_latency", 32'(n), 32'd10);
`ifdef SMARTBING_FALL_PULSE_EN
        check("t6_fall_pulse", 32'(su_fall), 32'd1);
        step();
        check("t6_fall_once", 32'(su_fall), 32'd0);
`endif
        su_raw = 1'b1;
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        su_raw = 1'b0; lh_raw = 1'b0; ll_raw = 1'b0;
        model_reset();
        #1;
        check("t6_reset_async", 32'(dut_vec()), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            step();
            cnt += int'(su_rise) + int'(lh_rise) + int'(ll_rise);
        end
        check("t6_no_pulse_after_reset", 32'(cnt), 32'd0);
        check("t6_levels_zero", 32'({ll_lvl, lh_lvl, su_lvl}), 32'd0);

        // Random phase: sparse raw changes, occasional disable and clear
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(7) == 0) su_raw = ~su_raw;
            if ($urandom_range(9) == 0) lh_raw = ~lh_raw;
            if ($urandom_range(9) == 0) ll_raw = ~ll_raw;
            en        = ($urandom_range(9) != 0);
            fault_clr = ($urandom_range(11) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
